ex_issue: RTL and testbench
===========================

EX_ISSUE -- requirements
Module: ex_issue

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the issued-instruction counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous kill of all held instructions.
REQ-005 SHALL have port in_valid  input  1  upstream instruction and operands valid.
REQ-006 SHALL have port in_ready  output  1  stage accepts this cycle.
REQ-007 SHALL have port in_instr  input  32  RV32 instruction word.
REQ-008 SHALL have port in_rs1_data  input  32  rs1 register value.
REQ-009 SHALL have port in_rs2_data  input  32  rs2 register value.
REQ-010 SHALL have port out_valid  output  1  registered operands valid to ALU.
REQ-011 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-012 SHALL have ports out_a and out_b  output  32 each  ALU operands A and B.
REQ-013 SHALL have port out_alu_ctrl  output  4  ALU opcode.
REQ-014 SHALL have port out_rd  output  5  destination register index.
REQ-015 SHALL have port out_we  output  1  register write enable.
REQ-016 SHALL have port out_illegal  output  1  instruction not supported.
REQ-017 SHALL have port issue_cnt  output  CNT_W  count of output handshakes.

Function
REQ-018 SHALL transfer on input when in_valid&&in_ready and on output when out_valid&&out_ready.
REQ-019 SHALL present an accepted instruction on out_* exactly 1 cycle after acceptance when the stage was empty.
REQ-020 SHALL hold out_* stable while out_valid&&!out_ready.
REQ-021 SHALL decode opcode 0110011 (R): funct3/funct7 000/0000000 ADD=0000, 000/0100000 SUB=0001, 111/0 AND=0010, 110/0 OR=0100, 100/0 XOR=1000, 101/0 SRL=1001, 001/0 SLL=1010; out_b=rs2.
REQ-022 SHALL decode opcode 0010011 (I): ADDI, ANDI, ORI, XORI with out_b = sign-extended instr[31:20]; SLLI/SRLI (funct7=0) with out_b = zero-extended instr[24:20]; out_a=rs1 always.
REQ-023 SHALL flag every other encoding (SRA/SRAI, SLT*, other opcodes) as illegal: out_illegal=1, out_alu_ctrl=0000, out_we=0, out_a=out_b=0.
REQ-024 SHALL drive out_we=0 when rd==0, else 1 for legal instructions.
REQ-025 SHALL increment issue_cnt by 1 per output handshake, wrapping from all-ones to 0.
REQ-026 SHALL, on flush, clear all valid state next cycle; flush dominates a same-cycle input handshake (instruction dropped) and issue_cnt still counts a same-cycle output handshake.

Reset
REQ-027 SHALL on rst: out_valid=0, issue_cnt=0, out_a=out_b=0, out_alu_ctrl=0000, out_rd=0, out_we=0, out_illegal=0; in_ready=1 the cycle after rst deasserts.
REQ-028 SHALL give rst priority over flush and handshakes; rst mid-transfer discards the held instruction.

Configuration
REQ-029 SHALL, with EX_ISSUE_SKID_EN defined, include a one-entry skid buffer: in_ready is a register equal to !skid_full, an instruction accepted while out stalled goes to skid, skid moves to output on the next output handshake; no combinational path out_ready->in_ready.
REQ-030 SHALL, without EX_ISSUE_SKID_EN, use a single output register with in_ready = !out_valid || out_ready (combinational).
REQ-031 SHALL preserve program order and 1-cycle latency in both builds.

Structure
REQ-032 SHALL place opcode constants (OP_R=0110011, OP_I=0010011) and the 4-bit ALU opcode constants in shared package ex_pkg used by ALU and this block.
REQ-033 SHALL isolate decode in combinational sub-module ex_issue_decode (instr, rs1, rs2 -> a, b, ctrl, rd, we, illegal).

Verification
REQ-034 SHALL check: add x3,x1,x2 with rs1=5, rs2=7 -> next cycle out_valid=1, a=5, b=7, ctrl=0000, rd=3, we=1.
REQ-035 SHALL check: addi x4,x0,-1 -> b=0xFFFFFFFF, ctrl=0000; srli x5,x1,31 -> b=31, ctrl=1001; sra encoding -> illegal=1, we=0.
REQ-036 SHALL check: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable; skid build accepts exactly 1 extra then in_ready=0; order preserved on release.
REQ-037 SHALL check: flush with in_valid&&in_ready -> out_valid=0 next cycle, instruction never appears, issue_cnt unchanged.
REQ-038 SHALL check: CNT_W=4, 17 handshakes -> issue_cnt=1; rst mid-stall -> all outputs reset values next cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared RV32 opcode and ALU opcode constants plus the issue payload type
package ex_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0100,
        ALU_XOR = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SLL = 4'b1010
    } alu_op_e;

    // Everything the ALU needs for one instruction, kept together so the
    // output register and the skid entry are the same shape.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/ex_issue_decode.sv
// rtl/ex_issue_decode.sv - combinational RV32 R/I ALU decode to operands and ALU opcode
// Ports: instr_i/rs1_i/rs2_i in; a_o/b_o operands, ctrl_o ALU opcode, rd_o, we_o, illegal_o out.
module ex_issue_decode
    import ex_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [3:0]  ctrl_o,
    output logic [4:0]  rd_o,
    output logic        we_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_s;
    logic [31:0] shamt;
    logic [31:0] b_raw;
    alu_op_e     op;
    logic        legal;
    logic        unused_rs1_idx;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign shamt  = {27'd0, instr_i[24:20]};

    // Register indices are resolved upstream; only the data arrives here.
    assign unused_rs1_idx = ^instr_i[19:15];

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        b_raw = rs2_i;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  op = ALU_ADD;
                        3'b111:  op = ALU_AND;
                        3'b110:  op = ALU_OR;
                        3'b100:  op = ALU_XOR;
                        3'b101:  op = ALU_SRL;
                        3'b001:  op = ALU_SLL;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal = 1'b1;
                    op    = ALU_SUB;
                end
            end
            OP_I: begin
                legal = 1'b1;
                b_raw = imm_s;
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b111: op = ALU_AND;
                    3'b110: op = ALU_OR;
                    3'b100: op = ALU_XOR;
                    // Shift-immediates take a 5-bit shamt; a nonzero funct7
                    // (SRAI or junk) is not supported.
                    3'b001: begin
                        op    = ALU_SLL;
                        b_raw = shamt;
                        legal = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        op    = ALU_SRL;
                        b_raw = shamt;
                        legal = (funct7 == F7_BASE);
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    assign a_o       = legal ? rs1_i : 32'd0;
    assign b_o       = legal ? b_raw : 32'd0;
    assign ctrl_o    = legal ? op : ALU_ADD;
    assign rd_o      = instr_i[11:7];
    assign we_o      = legal && (rd_o != 5'd0);
    assign illegal_o = !legal;

endmodule

// File: rtl/ex_issue.sv
// rtl/ex_issue.sv - execute issue stage: decode, register ALU operands, count issued instructions
// Ports: clk, rst (sync active-high), flush; in_valid/in_ready/in_instr/in_rs1_data/in_rs2_data upstream;
// out_valid/out_ready/out_a/out_b/out_alu_ctrl/out_rd/out_we/out_illegal downstream; issue_cnt.
// Build option: EX_ISSUE_SKID_EN adds a one-entry skid buffer and a registered in_ready.
module ex_issue
    import ex_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1_data,
    input  logic [31:0]      in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [3:0]       out_alu_ctrl,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_ctrl;
    logic [4:0]  dec_rd;
    logic        dec_we;
    logic        dec_illegal;
    issue_t      dec;

    issue_t           out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire;
    logic             out_fire;

    ex_issue_decode u_decode (
        .instr_i   (in_instr),
        .rs1_i     (in_rs1_data),
        .rs2_i     (in_rs2_data),
        .a_o       (dec_a),
        .b_o       (dec_b),
        .ctrl_o    (dec_ctrl),
        .rd_o      (dec_rd),
        .we_o      (dec_we),
        .illegal_o (dec_illegal)
    );

    assign dec = '{a: dec_a, b: dec_b, ctrl: dec_ctrl, rd: dec_rd,
                   we: dec_we, illegal: dec_illegal};

`ifdef EX_ISSUE_SKID_EN
    issue_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    // Registered ready breaks the out_ready -> in_ready path; the skid entry
    // absorbs the one instruction that may arrive while the output stalls.
    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q + CNT_W'(out_fire);
`ifdef EX_ISSUE_SKID_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_fire) begin
            // Skid is older than anything on the input, so it goes first;
            // in_ready is low whenever skid is full, so no input competes.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = dec;
                end
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
`else
        if (in_fire) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            cnt_q        <= '0;
`ifdef EX_ISSUE_SKID_EN
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
`endif
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            cnt_q        <= cnt_d;
`ifdef EX_ISSUE_SKID_EN
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
`endif
        end
    end

    assign out_valid    = out_valid_q;
    assign out_a        = out_q.a;
    assign out_b        = out_q.b;
    assign out_alu_ctrl = out_q.ctrl;
    assign out_rd       = out_q.rd;
    assign out_we       = out_q.we;
    assign out_illegal  = out_q.illegal;
    assign issue_cnt    = cnt_q;

endmodule

// File: tb/tb_ex_issue.sv
// tb/tb_ex_issue.sv - scoreboard bench for ex_issue with directed decode, stall, flush, reset and wrap vectors
module tb_ex_issue;

    localparam int CNT_W = 4;
`ifdef EX_ISSUE_SKID_EN
    localparam int EXP_EXTRA = 1;
`else
    localparam int EXP_EXTRA = 0;
`endif
    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_instr, in_rs1_data, in_rs2_data, out_a, out_b;
    logic [3:0]       out_alu_ctrl;
    logic [4:0]       out_rd;
    logic             out_we, out_illegal;
    logic [CNT_W-1:0] issue_cnt;

    always #5 clk = ~clk;

    ex_issue #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_alu_ctrl (out_alu_ctrl),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .out_illegal  (out_illegal),
        .issue_cnt    (issue_cnt)
    );

    vec_t             vecs[$];
    exp_t             exp_q[$];
    exp_t             cur_exp;
    logic [CNT_W-1:0] exp_cnt;
    logic             accepted;
    int               checks = 0;
    int               errors = 0;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic void addv(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                                 input logic [4:0] rd, input logic we, input logic ill);
        vec_t v;
        v.instr = instr;
        v.rs1   = r1;
        v.rs2   = r2;
        v.e     = {a, b, c, rd, we, ill};
        vecs.push_back(v);
    endfunction

    function automatic exp_t dut_out();
        return {out_a, out_b, out_alu_ctrl, out_rd, out_we, out_illegal};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted && !flush && !rst) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        in_instr    = vecs[i].instr;
        in_rs1_data = vecs[i].rs1;
        in_rs2_data = vecs[i].rs2;
        cur_exp     = vecs[i].e;
        in_valid    = 1'b1;
    endtask

    task automatic issue(input int i);
        int n = 0;
        drive(i);
        do begin
            tick();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: vector %0d not accepted within 50 cycles", i);
        end
    endtask

    // Monitor: every output handshake pops one expected entry.
    initial begin
        exp_t got;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                got = dut_out();
                chk("issue_cnt", 80'(issue_cnt), 80'(exp_cnt));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: actual %0h required none", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_payload", 80'(got), 80'(e));
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            if (rst) exp_cnt = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int extra;
        int n;
        logic [CNT_W-1:0] pre_cnt;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
        cur_exp = '0; exp_cnt = '0; accepted = 1'b0;

        addv(rtype(7'h00, 2, 1, 3'b000, 3),  5, 7, 5, 7, 4'h0, 3, 1, 0);
        addv(rtype(7'h20, 2, 1, 3'b000, 6),  10, 3, 10, 3, 4'h1, 6, 1, 0);
        addv(rtype(7'h00, 2, 1, 3'b111, 7),  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'h2, 7, 1, 0);
        addv(rtype(7'h00, 2, 1, 3'b110, 8),  1, 2, 1, 2, 4'h4, 8, 1, 0);
        addv(rtype(7'h00, 2, 1, 3'b100, 9),  32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555, 4'h8, 9, 1, 0);
        addv(rtype(7'h00, 2, 1, 3'b101, 10), 32'h8000_0000, 4, 32'h8000_0000, 4, 4'h9, 10, 1, 0);
        addv(rtype(7'h00, 2, 1, 3'b001, 11), 3, 2, 3, 2, 4'hA, 11, 1, 0);
        addv(rtype(7'h20, 2, 1, 3'b101, 12), 9, 9, 0, 0, 4'h0, 12, 0, 1);
        addv(rtype(7'h00, 2, 1, 3'b000, 0),  1, 1, 1, 1, 4'h0, 0, 0, 0);
        addv(itype(12'hFFF, 0, 3'b000, 4, OPI), 0, 123, 0, 32'hFFFF_FFFF, 4'h0, 4, 1, 0);
        addv(itype({7'h00, 5'd31}, 1, 3'b101, 5, OPI), 32'h8000_0000, 0, 32'h8000_0000, 31, 4'h9, 5, 1, 0);
        addv(itype({7'h20, 5'd3}, 1, 3'b101, 5, OPI), 6, 6, 0, 0, 4'h0, 5, 0, 1);
        addv(itype({7'h00, 5'd4}, 1, 3'b001, 13, OPI), 7, 99, 7, 4, 4'hA, 13, 1, 0);
        addv(itype(12'h0F0, 1, 3'b111, 14, OPI), 32'hFF, 0, 32'hFF, 32'hF0, 4'h2, 14, 1, 0);
        addv(itype(12'h800, 1, 3'b110, 15, OPI), 1, 0, 1, 32'hFFFF_F800, 4'h4, 15, 1, 0);
        addv(itype(12'h7FF, 1, 3'b100, 16, OPI), 2, 0, 2, 32'h7FF, 4'h8, 16, 1, 0);
        addv(itype(12'h005, 1, 3'b010, 17, OPI), 3, 3, 0, 0, 4'h0, 17, 0, 1);
        addv(itype(12'h004, 1, 3'b000, 18, 7'b0000011), 3, 3, 0, 0, 4'h0, 18, 0, 1);
        addv(rtype(7'h01, 2, 1, 3'b000, 19), 4, 4, 0, 0, 4'h0, 19, 0, 1);
        addv(itype({7'h01, 5'd2}, 1, 3'b001, 20, OPI), 4, 4, 0, 0, 4'h0, 20, 0, 1);
        addv(itype(12'h005, 1, 3'b000, 0, OPI), 8, 0, 8, 5, 4'h0, 0, 0, 0);

        // Reset state
        tick(); tick();
        chk("reset_out", {out_valid, dut_out(), issue_cnt}, '0);
        rst = 1'b0;
        tick();
        chk("reset_in_ready", 80'(in_ready), 80'(1));

        // add x3,x1,x2 visible exactly one cycle after acceptance
        issue(0);
        chk("add_latency", {out_valid, dut_out()}, {1'b1, vecs[0].e});
        for (int i = 1; i < vecs.size(); i++) issue(i);
        in_valid = 1'b0;
        repeat (3) tick();

        // Stall: hold output steady, count extra accepts
        out_ready = 1'b0;
        issue(1);
        drive(2);
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (accepted) extra++;
            chk("stall_hold", {out_valid, dut_out()}, {1'b1, vecs[1].e});
        end
        chk("stall_extra", 80'(extra), 80'(EXP_EXTRA));
        chk("stall_in_ready", 80'(in_ready), 80'(0));
        out_ready = 1'b1;
        n = 0;
        while (extra == 0 && n < 20) begin
            tick();
            if (accepted) extra++;
            n++;
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stall_drain", 80'(exp_q.size()), 80'(0));

        // Flush against a same-cycle input handshake on an empty stage
        pre_cnt = issue_cnt;
        drive(3);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("flush_in_valid", 80'(out_valid), 80'(0));
        chk("flush_cnt", 80'(issue_cnt), 80'(pre_cnt));
        repeat (3) tick();

        // Flush while holding a stalled instruction (and skid entry if present)
        out_ready = 1'b0;
        issue(4);
        drive(5);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        chk("flush_held_valid", 80'(out_valid), 80'(0));
        chk("flush_held_ready", 80'(in_ready), 80'(1));
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset in the middle of a stall
        out_ready = 1'b0;
        issue(6);
        drive(7);
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("rst_mid_stall", {out_valid, dut_out(), issue_cnt}, '0);
        tick();
        chk("rst_in_ready", 80'(in_ready), 80'(1));
        out_ready = 1'b1;

        // 17 handshakes on a 4-bit counter wrap to 1
        for (int i = 0; i < 17; i++) issue(i % vecs.size());
        in_valid = 1'b0;
        repeat (3) tick();
        chk("cnt_wrap", 80'(issue_cnt), 80'(1));
        chk("final_drain", 80'(exp_q.size()), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
